// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data ports and the downstream SRAM-style requestor port of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_port_arbiter_if;
   logic [31:0] if_addr;
   logic        if_c_en;
   logic [31:0] if_rdata;
   logic        if_error;
   logic        if_stall;

   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_c_en;
   logic        dm_w_en;
   logic [3:0]  dm_b_en;
   logic [31:0] dm_rdata;
   logic        dm_error;
   logic        dm_stall;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_c_en;
   logic        mem_w_en;
   logic [3:0]  mem_b_en;
   logic [31:0] mem_rdata;
   logic        mem_error;
   logic        mem_stall;

   modport slave (
      input  if_addr, if_c_en,
      output if_rdata, if_error, if_stall,
      input  dm_addr, dm_wdata, dm_c_en, dm_w_en, dm_b_en,
      output dm_rdata, dm_error, dm_stall,
      output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
      input  mem_rdata, mem_error, mem_stall
   );

   modport master (
      output if_addr, if_c_en,
      input  if_rdata, if_error, if_stall,
      output dm_addr, dm_wdata, dm_c_en, dm_w_en, dm_b_en,
      input  dm_rdata, dm_error, dm_stall,
      input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
      output mem_rdata, mem_error, mem_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data, one transaction at a time,
// with a stall watchdog. Define MEM_PORT_ARB_RR_EN for round-robin; otherwise data has priority.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input logic               ACLK,
   input logic               ARESET,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   localparam logic OwnFetch = 1'b0;
   localparam logic OwnData  = 1'b1;

   localparam bit          WdEn        = (TIMEOUT_CYCLES != 0);
   localparam int unsigned TimeoutLast = WdEn ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CntLast = TimeoutLast[CNT_W-1:0];

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic [31:0]      req_wdata_q, req_wdata_d;
   logic             req_w_en_q, req_w_en_d;
   logic [3:0]       req_b_en_q, req_b_en_d;
   logic [31:0]      res_rdata_q, res_rdata_d;
   logic             res_error_q, res_error_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic grant_data;
   logic wd_expire;
   logic busy;
   logic resp_fetch;
   logic resp_data;

`ifdef MEM_PORT_ARB_RR_EN
   // Under contention the port that did not win last time goes next.
   assign grant_data = bus.dm_c_en && (!bus.if_c_en || (last_grant_q == OwnFetch));
`else
   assign grant_data = bus.dm_c_en;
`endif

   assign wd_expire = WdEn && (cnt_q == CntLast);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= StIdle;
         owner_q      <= OwnFetch;
         last_grant_q <= OwnData;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_w_en_q   <= 1'b0;
         req_b_en_q   <= '0;
         res_rdata_q  <= '0;
         res_error_q  <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_w_en_q   <= req_w_en_d;
         req_b_en_q   <= req_b_en_d;
         res_rdata_q  <= res_rdata_d;
         res_error_q  <= res_error_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_w_en_d   = req_w_en_q;
      req_b_en_d   = req_b_en_q;
      res_rdata_d  = res_rdata_q;
      res_error_d  = res_error_q;
      cnt_d        = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (bus.if_c_en || bus.dm_c_en) begin
               state_d = StBusy;
               if (grant_data) begin
                  owner_d     = OwnData;
                  req_addr_d  = bus.dm_addr;
                  req_wdata_d = bus.dm_wdata;
                  req_w_en_d  = bus.dm_w_en;
                  req_b_en_d  = bus.dm_b_en;
               end else begin
                  owner_d     = OwnFetch;
                  req_addr_d  = bus.if_addr;
                  req_wdata_d = '0;
                  req_w_en_d  = 1'b0;
                  req_b_en_d  = 4'hF;
               end
            end
         end
         StBusy: begin
            if (!bus.mem_stall) begin
               res_rdata_d = bus.mem_rdata;
               res_error_d = bus.mem_error;
               cnt_d       = '0;
               state_d     = StResp;
            end else if (wd_expire) begin
               res_rdata_d = '0;
               res_error_d = 1'b1;
               cnt_d       = '0;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            last_grant_d = owner_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy       = (state_q == StBusy);
   assign resp_fetch = (state_q == StResp) && (owner_q == OwnFetch);
   assign resp_data  = (state_q == StResp) && (owner_q == OwnData);

   // Request outputs come straight from registers, so they cannot move while the master stalls.
   assign bus.mem_c_en  = busy;
   assign bus.mem_addr  = busy ? req_addr_q  : '0;
   assign bus.mem_wdata = busy ? req_wdata_q : '0;
   assign bus.mem_w_en  = busy && req_w_en_q;
   assign bus.mem_b_en  = busy ? req_b_en_q  : '0;

   assign bus.if_stall = bus.if_c_en && !resp_fetch;
   assign bus.dm_stall = bus.dm_c_en && !resp_data;
   assign bus.if_rdata = resp_fetch ? res_rdata_q : '0;
   assign bus.if_error = resp_fetch && res_error_q;
   assign bus.dm_rdata = resp_data ? res_rdata_q : '0;
   assign bus.dm_error = resp_data && res_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected downstream requests
// and responses; a monitor process pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        w_en;
      logic [3:0]  b_en;
   } req_t;

   typedef struct {
      logic        is_data;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic ACLK = 1'b0;
   logic ARESET;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .TIMEOUT_CYCLES(4),
      .CNT_W         (8)
   ) dut (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .bus   (bus)
   );

   always #5 ACLK = ~ACLK;

   // Memory model: stalls the first stall_cfg cycles of each BUSY period.
   int unsigned stall_cfg = 0;
   logic [31:0] rdata_cfg = '0;
   logic        err_cfg   = 1'b0;
   int unsigned busy_cnt;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET)            busy_cnt <= 0;
      else if (bus.mem_c_en) busy_cnt <= busy_cnt + 1;
      else                   busy_cnt <= 0;
   end

   assign bus.mem_stall = bus.mem_c_en && (busy_cnt < stall_cfg);
   assign bus.mem_rdata = rdata_cfg;
   assign bus.mem_error = err_cfg;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rsp_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic push_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [3:0] be);
      req_t r;
      r.addr = a; r.wdata = wd; r.w_en = we; r.b_en = be;
      req_q.push_back(r);
   endtask

   task automatic push_rsp(input logic d, input logic [31:0] rd, input logic e);
      rsp_t r;
      r.is_data = d; r.rdata = rd; r.err = e;
      rsp_q.push_back(r);
   endtask

   task automatic monitor();
      bit   in_busy = 0;
      req_t cur;
      rsp_t e;
      logic f_rsp, d_rsp;
      cur.addr = '0; cur.wdata = '0; cur.w_en = 1'b0; cur.b_en = '0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            in_busy = 0;
         end else begin
            if (bus.mem_c_en) begin
               if (!in_busy) begin
                  in_busy = 1;
                  chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                  if (req_q.size() != 0) cur = req_q.pop_front();
               end
               chk("mem_addr", bus.mem_addr, cur.addr);
               chk("mem_wdata", bus.mem_wdata, cur.wdata);
               chk("mem_w_en", 32'(bus.mem_w_en), 32'(cur.w_en));
               chk("mem_b_en", 32'(bus.mem_b_en), 32'(cur.b_en));
            end else begin
               in_busy = 0;
               chk("mem_idle", bus.mem_addr | bus.mem_wdata | 32'({bus.mem_w_en, bus.mem_b_en}),
                   32'd0);
            end
            f_rsp = bus.if_c_en && !bus.if_stall;
            d_rsp = bus.dm_c_en && !bus.dm_stall;
            if (f_rsp || d_rsp) begin
               rsp_seen++;
               chk("single_owner", 32'(f_rsp && d_rsp), 32'd0);
               chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
               if (rsp_q.size() != 0) begin
                  e = rsp_q.pop_front();
                  chk("rsp_port", 32'(d_rsp), 32'(e.is_data));
                  chk("rsp_rdata", d_rsp ? bus.dm_rdata : bus.if_rdata, e.rdata);
                  chk("rsp_error", 32'(d_rsp ? bus.dm_error : bus.if_error), 32'(e.err));
                  if (d_rsp) chk("if_quiet", bus.if_rdata | 32'(bus.if_error), 32'd0);
                  else       chk("dm_quiet", bus.dm_rdata | 32'(bus.dm_error), 32'd0);
               end
            end
         end
      end
   endtask

   // Waits for the response on one port, checks its latency, drops c_en, then checks it was one cycle.
   task automatic wait_rsp(input logic is_data, input int lat);
      int got = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge ACLK);
         if (!(is_data ? bus.dm_stall : bus.if_stall)) begin
            got = i;
            break;
         end
      end
      chk(is_data ? "dm_latency" : "if_latency", got, lat);
      @(posedge ACLK);
      #1;
      if (is_data) bus.dm_c_en = 1'b0;
      else         bus.if_c_en = 1'b0;
      @(negedge ACLK);
      chk("rsp_one_cycle", bus.if_rdata | bus.dm_rdata | 32'({bus.if_error, bus.dm_error}), 32'd0);
   endtask

   task automatic do_fetch(input logic [31:0] a, input int unsigned stall, input logic [31:0] mrd,
                           input logic merr, input logic [31:0] erd, input logic eerr,
                           input int lat);
      @(posedge ACLK);
      #1;
      stall_cfg = stall; rdata_cfg = mrd; err_cfg = merr;
      push_req(a, 32'h0, 1'b0, 4'hF);
      push_rsp(1'b0, erd, eerr);
      bus.if_addr = a;
      bus.if_c_en = 1'b1;
      wait_rsp(1'b0, lat);
   endtask

   task automatic do_data(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [3:0] be, input int unsigned stall, input logic [31:0] mrd,
                          input logic merr, input logic [31:0] erd, input logic eerr,
                          input int lat);
      @(posedge ACLK);
      #1;
      stall_cfg = stall; rdata_cfg = mrd; err_cfg = merr;
      push_req(a, wd, we, be);
      push_rsp(1'b1, erd, eerr);
      bus.dm_addr  = a;
      bus.dm_wdata = wd;
      bus.dm_w_en  = we;
      bus.dm_b_en  = be;
      bus.dm_c_en  = 1'b1;
      wait_rsp(1'b1, lat);
   endtask

   task automatic pulse_reset();
      @(posedge ACLK);
      #1 ARESET = 1'b1;
      @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   initial begin
      int got;
      int n_grants;
      ARESET      = 1'b1;
      bus.if_addr = '0;
      bus.if_c_en = 1'b1;
      bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_c_en = 1'b0; bus.dm_w_en = 1'b0;
      bus.dm_b_en = '0;
      fork
         monitor();
      join_none

      // Reset state, with a fetch request pending.
      #2;
      chk("rst_mem_c_en", 32'(bus.mem_c_en), 32'd0);
      chk("rst_mem_bus", bus.mem_addr | bus.mem_wdata | 32'({bus.mem_w_en, bus.mem_b_en}), 32'd0);
      chk("rst_if_stall", 32'(bus.if_stall), 32'd1);
      chk("rst_dm_stall", 32'(bus.dm_stall), 32'd0);
      chk("rst_rdata", bus.if_rdata | bus.dm_rdata | 32'({bus.if_error, bus.dm_error}), 32'd0);
      bus.if_c_en = 1'b0;
      @(posedge ACLK);
      #1 ARESET = 1'b0;

      do_fetch(32'h100, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 2);
      do_data(32'h2000, 32'h12345678, 1'b1, 4'b0011, 3, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0,
              5);
      do_data(32'h3004, 32'h0, 1'b0, 4'hF, 0, 32'h000055AA, 1'b1, 32'h000055AA, 1'b1, 2);
      do_fetch(32'h400, 100, 32'h11111111, 1'b0, 32'h0, 1'b1, 5);
      do_data(32'h3008, 32'h0, 1'b0, 4'b1100, 1, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0, 3);
      do_fetch(32'h104, 2, 32'h87654321, 1'b0, 32'h87654321, 1'b0, 4);

      // Continuous contention from a fresh reset (last_grant = DATA).
      pulse_reset();
      @(posedge ACLK);
      #1;
      stall_cfg = 0; rdata_cfg = 32'h5A5A0000; err_cfg = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      n_grants = 4;
      for (int k = 0; k < 2; k++) begin
         push_req(32'h500, 32'h0, 1'b0, 4'hF);        push_rsp(1'b0, 32'h5A5A0000, 1'b0);
         push_req(32'h600, 32'hF00D, 1'b1, 4'b0101);  push_rsp(1'b1, 32'h5A5A0000, 1'b0);
      end
`else
      n_grants = 3;
      for (int k = 0; k < 3; k++) begin
         push_req(32'h600, 32'hF00D, 1'b1, 4'b0101);  push_rsp(1'b1, 32'h5A5A0000, 1'b0);
      end
`endif
      bus.if_addr = 32'h500;
      bus.dm_addr = 32'h600; bus.dm_wdata = 32'hF00D; bus.dm_w_en = 1'b1; bus.dm_b_en = 4'b0101;
      got = rsp_seen;
      bus.if_c_en = 1'b1;
      bus.dm_c_en = 1'b1;
      n_grants = got + n_grants;
      got = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge ACLK);
         #1;
         if (rsp_seen == n_grants) begin
            got = i;
            break;
         end
      end
`ifdef MEM_PORT_ARB_RR_EN
      chk("contend_cycles", got, 11);
`else
      chk("contend_cycles", got, 8);
`endif
      @(posedge ACLK);
      #1;
      bus.if_c_en = 1'b0;
      bus.dm_c_en = 1'b0;

      // Reset during BUSY abandons the transfer; the still-pending request re-arbitrates.
      @(posedge ACLK);
      #1;
      stall_cfg = 50; rdata_cfg = 32'h77777777; err_cfg = 1'b0;
      push_req(32'h700, 32'h0, 1'b0, 4'hF);
      bus.dm_addr = 32'h700; bus.dm_wdata = 32'h0; bus.dm_w_en = 1'b0; bus.dm_b_en = 4'hF;
      bus.dm_c_en = 1'b1;
      @(negedge ACLK);
      @(negedge ACLK);
      chk("busy_before_rst", 32'(bus.mem_c_en), 32'd1);
      #2 ARESET = 1'b1;
      #1;
      chk("rst_async_c_en", 32'(bus.mem_c_en), 32'd0);
      chk("rst_dm_stall", 32'(bus.dm_stall), 32'd1);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      stall_cfg = 0;
      push_req(32'h700, 32'h0, 1'b0, 4'hF);
      push_rsp(1'b1, 32'h77777777, 1'b0);
      wait_rsp(1'b1, 2);

      repeat (3) @(negedge ACLK);
      chk("req_q_drained", req_q.size(), 32'd0);
      chk("rsp_q_drained", rsp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
